load_store_unit: RTL and testbench

- Memory-stage initiator for the CPU's data RAM port. Accepts one load/store request at a time: byte, halfword or word, signed or unsigned.
- On the RAM side it drives only aligned word accesses. Sub-word loads use lane extraction plus extension. Sub-word stores use read-modify-write.
- Sits between the pipeline memory stage and the 16 KB little-endian data RAM. The RAM has a 1-cycle registered read.

---
 rtl/load_store_unit_pkg.sv | 47 ++++
 rtl/load_store_unit_lane_align.sv | 70 +++++++
 rtl/load_store_unit.sv | 165 ++++++++++++++++
 tb/tb_load_store_unit.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// -----------------------------------------------------------------------------
// load_store_unit_pkg
// Shared definitions for the load/store unit and its lane-align helper:
//   - `WordWidth : data word width (32)
//   - SIZE_*     : request size encodings
//   - lsu_state_e: FSM state encoding
//   - is_sub_word / is_misaligned helpers
// -----------------------------------------------------------------------------
`ifndef WordWidth
`define WordWidth 32
`endif

package load_store_unit_pkg;

  localparam int WORD_WIDTH = `WordWidth;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_ISSUE = 3'd1,
    ST_RD_WAIT  = 3'd2,
    ST_WR       = 3'd3,
    ST_DONE     = 3'd4
  } lsu_state_e;

  // Byte and halfword stores need a read-modify-write; size 11 is a word.
  function automatic logic is_sub_word(input logic [1:0] size);
    return (size == SIZE_BYTE) || (size == SIZE_HALF);
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] offset);
    logic bad;
    bad = 1'b0;
    case (size)
      SIZE_BYTE: bad = 1'b0;
      SIZE_HALF: bad = offset[0];
      SIZE_WORD: bad = (offset != 2'b00);
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_store_unit_lane_align.sv
// -----------------------------------------------------------------------------
// lsu_lane_align
// Purely combinational lane handling for a little-endian 32-bit word:
//   - o_load  : lane selected by i_size/i_offset from i_word, sign- or
//               zero-extended according to i_signed.
//   - o_merged: i_word with the store lane replaced by the low bits of
//               i_wdata (other bytes kept), for read-modify-write stores.
// Ports:
//   i_size[1:0]  byte/half/word (11 handled as word)
//   i_signed     sign-extend sub-word loads
//   i_offset[1:0] byte offset within the word
//   i_word       word read from RAM
//   i_wdata      right-justified store data
// Halfword lane uses only i_offset[1]; word ignores i_offset entirely.
// -----------------------------------------------------------------------------
module lsu_lane_align
  import load_store_unit_pkg::*;
#(
  parameter int DATA_W = WORD_WIDTH
) (
  input  logic [1:0]        i_size,
  input  logic              i_signed,
  input  logic [1:0]        i_offset,
  input  logic [DATA_W-1:0] i_word,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_load,
  output logic [DATA_W-1:0] o_merged
);

  localparam logic [DATA_W-1:0] LOW_BYTE = {{(DATA_W-8){1'b0}}, 8'hFF};
  localparam logic [DATA_W-1:0] LOW_HALF = {{(DATA_W-16){1'b0}}, 16'hFFFF};

  logic [4:0]        w_byte_sh;
  logic [4:0]        w_half_sh;
  logic [DATA_W-1:0] w_byte_shifted;
  logic [DATA_W-1:0] w_half_shifted;
  logic [DATA_W-1:0] w_byte_mask;
  logic [DATA_W-1:0] w_half_mask;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so
    // no path through the case can leave it unassigned (which would infer
    // a latch).
    o_load   = i_word;
    o_merged = i_wdata;

    w_byte_sh      = {i_offset, 3'b000};
    w_half_sh      = {i_offset[1], 4'b0000};
    w_byte_shifted = i_word >> w_byte_sh;
    w_half_shifted = i_word >> w_half_sh;
    w_byte_mask    = LOW_BYTE << w_byte_sh;
    w_half_mask    = LOW_HALF << w_half_sh;

    case (i_size)
      SIZE_BYTE: begin
        o_load   = {{(DATA_W-8){i_signed & w_byte_shifted[7]}}, w_byte_shifted[7:0]};
        o_merged = (i_word & ~w_byte_mask) | ((i_wdata & LOW_BYTE) << w_byte_sh);
      end
      SIZE_HALF: begin
        o_load   = {{(DATA_W-16){i_signed & w_half_shifted[15]}}, w_half_shifted[15:0]};
        o_merged = (i_word & ~w_half_mask) | ((i_wdata & LOW_HALF) << w_half_sh);
      end
      default: begin
        o_load   = i_word;
        o_merged = i_wdata;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Memory-stage initiator for a 16 KB little-endian data RAM with a 1-cycle
// registered read. Accepts one byte/halfword/word load or store at a time
// and only ever issues aligned word accesses to the RAM; sub-word stores
// are done as read-modify-write.
//
// Optional feature (macro LSU_ALIGN_CHECK_EN): misaligned requests skip the
// RAM entirely, go straight to DONE and raise out_Fault with out_Done.
// Without the macro the out_Fault port does not exist and alignment is not
// checked (halfword ignores addr[0], word ignores addr[1:0], size 11 = word).
//
// Ports:
//   clock, reset_n            clock / async active-low reset
//   in_Req, in_Wr, in_Size,   request, sampled only while idle
//   in_Signed, in_Addr, in_Wdata
//   out_Busy                  high in every state but IDLE
//   out_Done                  one-cycle completion pulse
//   out_Rdata                 extended load result, held until next load
//   out_Fault                 misalignment pulse (optional feature only)
//   out_RamAddr, out_RamWrite, out_RamWdata, out_RamSize   RAM request
//   in_RamRdata               RAM read data, valid the cycle after address
// Latency from accept edge to Done: load 3, word store 2, sub-word store 4.
// -----------------------------------------------------------------------------
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_W = 14,
  parameter int DATA_W = `WordWidth
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_Req,
  input  logic              in_Wr,
  input  logic [1:0]        in_Size,
  input  logic              in_Signed,
  input  logic [ADDR_W-1:0] in_Addr,
  input  logic [DATA_W-1:0] in_Wdata,
  output logic              out_Busy,
  output logic              out_Done,
  output logic [DATA_W-1:0] out_Rdata,
`ifdef LSU_ALIGN_CHECK_EN
  output logic              out_Fault,
`endif
  output logic [ADDR_W-1:0] out_RamAddr,
  output logic              out_RamWrite,
  output logic [DATA_W-1:0] out_RamWdata,
  output logic [1:0]        out_RamSize,
  input  logic [DATA_W-1:0] in_RamRdata
);

  lsu_state_e        r_state;
  lsu_state_e        w_next_state;

  logic              r_wr;
  logic [1:0]        r_size;
  logic              r_signed;
  logic [1:0]        r_offset;
  logic [DATA_W-1:0] r_wdata;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_wdata;
  logic [DATA_W-1:0] r_rdata;

  logic              w_accept;
  logic              w_misaligned;
  logic [DATA_W-1:0] w_load;
  logic [DATA_W-1:0] w_merged;

  assign w_accept = (r_state == ST_IDLE) && in_Req;

`ifdef LSU_ALIGN_CHECK_EN
  logic r_fault;
  assign w_misaligned = is_misaligned(in_Size, in_Addr[1:0]);
  assign out_Fault    = (r_state == ST_DONE) && r_fault;
`else
  assign w_misaligned = 1'b0;
`endif

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (in_Req) begin
          if (w_misaligned)                       w_next_state = ST_DONE;
          else if (!in_Wr || is_sub_word(in_Size)) w_next_state = ST_RD_ISSUE;
          else                                    w_next_state = ST_WR;
        end
      end
      ST_RD_ISSUE: w_next_state = ST_RD_WAIT;
      ST_RD_WAIT:  w_next_state = r_wr ? ST_WR : ST_DONE;
      ST_WR:       w_next_state = ST_DONE;
      ST_DONE:     w_next_state = ST_IDLE;
      default:     w_next_state = ST_IDLE;
    endcase
  end

  // Request capture and RAM-side datapath
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr        <= 1'b0;
      r_size      <= SIZE_WORD;
      r_signed    <= 1'b0;
      r_offset    <= 2'b00;
      r_wdata     <= '0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_rdata     <= '0;
`ifdef LSU_ALIGN_CHECK_EN
      r_fault     <= 1'b0;
`endif
    end else begin
      if (w_accept) begin
        r_wr     <= in_Wr;
        r_size   <= in_Size;
        r_signed <= in_Signed;
        r_offset <= in_Addr[1:0];
        r_wdata  <= in_Wdata;
`ifdef LSU_ALIGN_CHECK_EN
        r_fault  <= w_misaligned;
`endif
        // A faulting request never touches the RAM, so the address is left
        // alone; a word store can present its data straight away.
        if (!w_misaligned) begin
          r_ram_addr <= {in_Addr[ADDR_W-1:2], 2'b00};
          if (in_Wr && !is_sub_word(in_Size)) r_ram_wdata <= in_Wdata;
        end
      end
      if (r_state == ST_RD_WAIT) begin
        if (r_wr) r_ram_wdata <= w_merged;
        else      r_rdata     <= w_load;
      end
    end
  end

  lsu_lane_align #(
    .DATA_W (DATA_W)
  ) u_lane_align (
    .i_size   (r_size),
    .i_signed (r_signed),
    .i_offset (r_offset),
    .i_word   (in_RamRdata),
    .i_wdata  (r_wdata),
    .o_load   (w_load),
    .o_merged (w_merged)
  );

  // Write strobe decoded from state so reset drops it immediately.
  assign out_Busy     = (r_state != ST_IDLE);
  assign out_Done     = (r_state == ST_DONE);
  assign out_RamWrite = (r_state == ST_WR);
  assign out_RamAddr  = r_ram_addr;
  assign out_RamWdata = r_ram_wdata;
  assign out_RamSize  = SIZE_WORD;
  assign out_Rdata    = r_rdata;

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
// Self-checking bench for load_store_unit: table of directed vectors, a few
// hand-written multi-cycle sequences, then random requests checked against
// a byte-array reference memory. Define LSU_ALIGN_CHECK_EN to exercise the
// alignment-fault build.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_load_store_unit;

  logic        clock;
  logic        reset_n;
  logic        in_Req;
  logic        in_Wr;
  logic [1:0]  in_Size;
  logic        in_Signed;
  logic [13:0] in_Addr;
  logic [31:0] in_Wdata;
  logic        out_Busy;
  logic        out_Done;
  logic [31:0] out_Rdata;
  logic [13:0] out_RamAddr;
  logic        out_RamWrite;
  logic [31:0] out_RamWdata;
  logic [1:0]  out_RamSize;
  logic [31:0] ram_rdata;
`ifdef LSU_ALIGN_CHECK_EN
  logic        out_Fault;
`endif

  load_store_unit #(.ADDR_W(14), .DATA_W(32)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .in_Req       (in_Req),
    .in_Wr        (in_Wr),
    .in_Size      (in_Size),
    .in_Signed    (in_Signed),
    .in_Addr      (in_Addr),
    .in_Wdata     (in_Wdata),
    .out_Busy     (out_Busy),
    .out_Done     (out_Done),
    .out_Rdata    (out_Rdata),
`ifdef LSU_ALIGN_CHECK_EN
    .out_Fault    (out_Fault),
`endif
    .out_RamAddr  (out_RamAddr),
    .out_RamWrite (out_RamWrite),
    .out_RamWdata (out_RamWdata),
    .out_RamSize  (out_RamSize),
    .in_RamRdata  (ram_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Data RAM: 4096 words, 1-cycle registered read, counts write cycles.
  logic [31:0] ram [0:4095] = '{default: 32'h0};
  int          n_writes = 0;

  always @(posedge clock) begin
    if (out_RamWrite) begin
      ram[out_RamAddr[13:2]] <= out_RamWdata;
      n_writes <= n_writes + 1;
    end
    ram_rdata <= ram[out_RamAddr[13:2]];
  end

  // Reference model: byte-addressed little-endian memory + last load value.
  logic [7:0]  ref_b [0:16383] = '{default: 8'h0};
  logic [31:0] ref_rdata = 32'h0;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [13:0] addr);
    int a;
    a = int'(addr) & ~3;
    return {ref_b[a+3], ref_b[a+2], ref_b[a+1], ref_b[a]};
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] size, input logic sgn,
                                           input logic [13:0] addr);
    logic [7:0]  b;
    logic [15:0] h;
    int          a;
    case (size)
      2'd0: begin
        b = ref_b[int'(addr)];
        return {{24{sgn & b[7]}}, b};
      end
      2'd1: begin
        a = int'(addr) & ~1;
        h = {ref_b[a+1], ref_b[a]};
        return {{16{sgn & h[15]}}, h};
      end
      default: return ref_word(addr);
    endcase
  endfunction

  task automatic ref_store(input logic [1:0] size, input logic [13:0] addr,
                           input logic [31:0] wd);
    int a;
    case (size)
      2'd0: ref_b[int'(addr)] = wd[7:0];
      2'd1: begin
        a = int'(addr) & ~1;
        ref_b[a]   = wd[7:0];
        ref_b[a+1] = wd[15:8];
      end
      default: begin
        a = int'(addr) & ~3;
        for (int k = 0; k < 4; k++) ref_b[a+k] = wd[8*k +: 8];
      end
    endcase
  endtask

  function automatic logic ref_misaligned(input logic [1:0] size, input logic [13:0] addr);
`ifdef LSU_ALIGN_CHECK_EN
    return (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  // Drive one request, measure edges from accept to Done (accept edge = 1).
  task automatic run_op(input logic wr, input logic [1:0] size, input logic sgn,
                        input logic [13:0] addr, input logic [31:0] wd,
                        output int lat, output int writes, output logic fault);
    int base;
    @(negedge clock);
    in_Wr = wr; in_Size = size; in_Signed = sgn; in_Addr = addr; in_Wdata = wd;
    in_Req = 1'b1;
    base = n_writes;
    @(posedge clock); #1;
    in_Req = 1'b0;
    lat = 1;
    while (out_Done !== 1'b1 && lat < 20) begin
      @(posedge clock); #1;
      lat++;
    end
`ifdef LSU_ALIGN_CHECK_EN
    fault = out_Fault;
`else
    fault = 1'b0;
`endif
    @(posedge clock); #1;
    writes = n_writes - base;
  endtask

  task automatic op_and_check(input string tag, input logic wr, input logic [1:0] size,
                              input logic sgn, input logic [13:0] addr, input logic [31:0] wd,
                              input logic [31:0] exp_rdata, input logic [31:0] exp_mem,
                              input int exp_lat, input int exp_writes, input logic exp_fault);
    int   lat;
    int   writes;
    logic fault;
    run_op(wr, size, sgn, addr, wd, lat, writes, fault);
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " rdata"}, out_Rdata, exp_rdata);
    check({tag, " mem"}, ram[addr[13:2]], exp_mem);
    check({tag, " writes"}, 32'(writes), 32'(exp_writes));
`ifdef LSU_ALIGN_CHECK_EN
    check({tag, " fault"}, {31'b0, fault}, {31'b0, exp_fault});
`else
    if (fault !== exp_fault) check({tag, " fault"}, {31'b0, fault}, {31'b0, exp_fault});
`endif
  endtask

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic        sgn;
    logic [13:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic [31:0] exp_mem;
    int          exp_lat;
  } vec_t;

  vec_t vecs [14];

  initial begin
    vecs[0]  = '{1'b1, 2'd2, 1'b0, 14'h010, 32'h8899AABB, 32'h00000000, 32'h8899AABB, 2};
    vecs[1]  = '{1'b0, 2'd2, 1'b0, 14'h010, 32'h0,        32'h8899AABB, 32'h8899AABB, 3};
    vecs[2]  = '{1'b0, 2'd0, 1'b1, 14'h013, 32'h0,        32'hFFFFFF88, 32'h8899AABB, 3};
    vecs[3]  = '{1'b0, 2'd0, 1'b0, 14'h013, 32'h0,        32'h00000088, 32'h8899AABB, 3};
    vecs[4]  = '{1'b0, 2'd1, 1'b1, 14'h012, 32'h0,        32'hFFFF8899, 32'h8899AABB, 3};
    vecs[5]  = '{1'b0, 2'd1, 1'b0, 14'h010, 32'h0,        32'h0000AABB, 32'h8899AABB, 3};
    vecs[6]  = '{1'b1, 2'd0, 1'b0, 14'h011, 32'hAAAAAA55, 32'h0000AABB, 32'h889955BB, 4};
    vecs[7]  = '{1'b1, 2'd1, 1'b0, 14'h012, 32'hFFFF1234, 32'h0000AABB, 32'h123455BB, 4};
    vecs[8]  = '{1'b0, 2'd2, 1'b0, 14'h010, 32'h0,        32'h123455BB, 32'h123455BB, 3};
    vecs[9]  = '{1'b0, 2'd0, 1'b1, 14'h010, 32'h0,        32'hFFFFFFBB, 32'h123455BB, 3};
    vecs[10] = '{1'b0, 2'd1, 1'b1, 14'h012, 32'h0,        32'h00001234, 32'h123455BB, 3};
    vecs[11] = '{1'b0, 2'd0, 1'b1, 14'h011, 32'h0,        32'h00000055, 32'h123455BB, 3};
    vecs[12] = '{1'b1, 2'd0, 1'b1, 14'h013, 32'h000000F0, 32'h00000055, 32'hF03455BB, 4};
    vecs[13] = '{1'b0, 2'd0, 1'b1, 14'h013, 32'h0,        32'hFFFFFFF0, 32'hF03455BB, 3};

    reset_n = 1'b0;
    in_Req = 1'b0; in_Wr = 1'b0; in_Size = 2'd0; in_Signed = 1'b0;
    in_Addr = '0; in_Wdata = '0;

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check("reset busy",     {31'b0, out_Busy},     32'h0);
    check("reset done",     {31'b0, out_Done},     32'h0);
    check("reset ramwrite", {31'b0, out_RamWrite}, 32'h0);
    check("reset rdata",    out_Rdata,             32'h0);
    check("reset ramaddr",  {18'b0, out_RamAddr},  32'h0);
    check("reset ramwdata", out_RamWdata,          32'h0);
    check("ramsize",        {30'b0, out_RamSize},  32'h2);
    @(negedge clock);
    reset_n = 1'b1;

    // Directed table
    for (int i = 0; i < 14; i++) begin
      if (vecs[i].wr) ref_store(vecs[i].size, vecs[i].addr, vecs[i].wdata);
      else            ref_rdata = ref_load(vecs[i].size, vecs[i].sgn, vecs[i].addr);
      op_and_check($sformatf("vec%0d", i), vecs[i].wr, vecs[i].size, vecs[i].sgn,
                   vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_mem,
                   vecs[i].exp_lat, vecs[i].wr ? 1 : 0, 1'b0);
    end

    // Word store with in_Req re-pulsed while busy: only one write happens.
    begin
      int base;
      @(negedge clock);
      in_Wr = 1'b1; in_Size = 2'd2; in_Signed = 1'b0; in_Addr = 14'h020;
      in_Wdata = 32'hDEADBEEF; in_Req = 1'b1;
      base = n_writes;
      @(posedge clock); #1;
      check("repulse busy", {31'b0, out_Busy}, 32'h1);
      in_Addr = 14'h024; in_Wdata = 32'h11111111;
      @(posedge clock); #1;
      check("repulse done at 2", {31'b0, out_Done}, 32'h1);
      in_Req = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      ref_store(2'd2, 14'h020, 32'hDEADBEEF);
      check("repulse writes", 32'(n_writes - base), 32'd1);
      check("repulse mem020", ram[14'h020 >> 2], 32'hDEADBEEF);
      check("repulse mem024", ram[14'h024 >> 2], ref_word(14'h024));
      check("repulse idle",   {31'b0, out_Busy}, 32'h0);
    end

    // Reset during RD_WAIT of a byte store: access abandoned.
    begin
      int base;
      @(negedge clock);
      in_Wr = 1'b1; in_Size = 2'd0; in_Signed = 1'b0; in_Addr = 14'h010;
      in_Wdata = 32'h00000077; in_Req = 1'b1;
      base = n_writes;
      @(posedge clock); #1;
      in_Req = 1'b0;
      @(posedge clock); #1;
      check("midreset busy before", {31'b0, out_Busy}, 32'h1);
      reset_n = 1'b0;
      #1;
      check("midreset busy",     {31'b0, out_Busy},     32'h0);
      check("midreset ramwrite", {31'b0, out_RamWrite}, 32'h0);
      @(negedge clock);
      reset_n = 1'b1;
      repeat (4) @(posedge clock);
      #1;
      ref_rdata = 32'h0;
      check("midreset writes", 32'(n_writes - base), 32'd0);
      check("midreset mem010", ram[14'h010 >> 2], 32'hF03455BB);
      check("midreset rdata",  out_Rdata, ref_rdata);
    end

`ifdef LSU_ALIGN_CHECK_EN
    // Misaligned halfword load: immediate fault, no RAM access.
    begin
      logic [13:0] addr_before;
      logic [31:0] rdata_before;
      addr_before  = out_RamAddr;
      rdata_before = out_Rdata;
      op_and_check("align", 1'b0, 2'd1, 1'b1, 14'h011, 32'h0, rdata_before,
                   ref_word(14'h011), 1, 0, 1'b1);
      check("align ramaddr", {18'b0, out_RamAddr}, {18'b0, addr_before});
    end
`endif

    // Random requests against the reference model.
    for (int i = 0; i < 80; i++) begin
      logic        wr;
      logic [1:0]  size;
      logic        sgn;
      logic [13:0] addr;
      logic [31:0] wd;
      logic        mis;
      int          exp_lat;
      wr   = 1'($urandom_range(0, 1));
      size = 2'($urandom_range(0, 3));
      sgn  = 1'($urandom_range(0, 1));
      addr = 14'($urandom_range(0, 63));
      wd   = $urandom;
      mis  = ref_misaligned(size, addr);
      if (mis)                                 exp_lat = 1;
      else if (!wr)                            exp_lat = 3;
      else if (size == 2'd0 || size == 2'd1)   exp_lat = 4;
      else                                     exp_lat = 2;
      if (!mis) begin
        if (wr) ref_store(size, addr, wd);
        else    ref_rdata = ref_load(size, sgn, addr);
      end
      op_and_check($sformatf("rnd%0d", i), wr, size, sgn, addr, wd, ref_rdata,
                   ref_word(addr), exp_lat, (wr && !mis) ? 1 : 0, mis);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
